// File: rtl/regfile_dump.sv
// Register-file dump engine: walks a wrapping index range on a combinational
// read port and streams each word out over a valid/ready handshake.
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] RD,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;
    index_d = index_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = first_reg;
          last_d  = last_reg;
          state_d = READ;
        end
      end
      READ: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          data_d  = RD;
          index_d = idx_q;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // abort wins over a handshake landing on the same edge
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (idx_q == last_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign A = (state_q == READ || state_q == SEND) ? idx_q : '0;
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed scoreboard bench for regfile_dump.
// Expected words are queued at start and popped on each handshake.
module tb_regfile_dump;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          Reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] first_reg;
  logic [AW-1:0] last_reg;
  logic [AW-1:0] A;
  logic [DW-1:0] RD;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [32];

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } word_t;

  word_t exp_q[$];
  int    hs_cyc[$];
  int    done_cyc;
  int    dones;
  int    checks;
  int    failures;

  regfile_dump #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .start     (start),
    .abort     (abort),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .A         (A),
    .RD        (RD),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .done      (done)
  );

  assign RD = mem[A];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input int f, input int l);
    int i;
    @(negedge clk);
    first_reg = AW'(f);
    last_reg  = AW'(l);
    start     = 1'b1;
    out_ready = 1'b1;
    i = f;
    forever begin
      exp_q.push_back('{idx: AW'(i), data: mem[i]});
      if (i == l) break;
      i = (i + 1) % 32;
    end
  endtask

  // Runs the dump to completion (or to an abort), comparing each handshake.
  task automatic drain(input int stall, input int abort_idx, input int bs_n);
    int n;
    int post;
    int stall_left;
    bit snap;
    bit fin;
    logic [DW-1:0] sd;
    logic [AW-1:0] si;
    word_t e;
    n = 0;
    post = 0;
    stall_left = stall;
    snap = 0;
    fin = 0;
    sd = '0;
    si = '0;
    dones = 0;
    done_cyc = -1;
    hs_cyc.delete();
    while (!fin && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      start = 1'b0;
      abort = 1'b0;
      if (n == bs_n) begin
        start     = 1'b1;
        first_reg = '0;
        last_reg  = '0;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (out_valid && stall_left > 0) begin
        if (!snap) begin
          sd = out_data;
          si = out_index;
          snap = 1;
        end else begin
          chk("stall_data", 64'(out_data), 64'(sd));
          chk("stall_index", 64'(out_index), 64'(si));
        end
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          hs_cyc.push_back(n);
          checks++;
          assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL extra_word observed=%0h expected=none", out_index);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("word_index", 64'(out_index), 64'(e.idx));
            chk("word_data", 64'(out_data), 64'(e.data));
          end
          if (abort_idx >= 0 && int'(out_index) == abort_idx) begin
            abort = 1'b1;
            fin = 1;
          end
        end
      end
      if (dones > 0) post++;
      if (post == 3) fin = 1;
    end
    checks++;
    assert (fin) else begin
      failures++;
      $error("FAIL drain_timeout observed=%0d expected=<200", n);
    end
    if (abort_idx < 0) begin
      chk("done_pulses", 64'(dones), 64'd1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) mem[i] = DW'(i * 32'h11);
    Reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    first_reg = '0;
    last_reg  = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_A", 64'(A), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    Reset = 1'b1;

    // basic range 2..4 with timing
    kick(2, 4);
    drain(0, -1, 0);
    chk("hs_count", 64'(hs_cyc.size()), 64'd3);
    if (hs_cyc.size() == 3) begin
      chk("hs_cyc0", 64'(hs_cyc[0]), 64'd2);
      chk("hs_cyc1", 64'(hs_cyc[1]), 64'd4);
      chk("hs_cyc2", 64'(hs_cyc[2]), 64'd6);
    end
    chk("done_cyc", 64'(done_cyc), 64'd7);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_A", 64'(A), 64'd0);

    // wrap 30..1
    kick(30, 1);
    drain(0, -1, 0);
    chk("wrap_count", 64'(hs_cyc.size()), 64'd4);

    // back-pressure on the first word
    kick(8, 9);
    drain(5, -1, 0);
    chk("stall_count", 64'(hs_cyc.size()), 64'd2);

    // start while busy must not disturb the range
    kick(5, 6);
    drain(0, -1, 3);
    chk("busy_start_cnt", 64'(hs_cyc.size()), 64'd2);

    // abort coincident with handshake of index 3
    kick(1, 6);
    drain(0, 3, 0);
    chk("abort_words", 64'(hs_cyc.size()), 64'd3);
    exp_q.delete();
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_A", 64'(A), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_quiet_v", 64'(out_valid), 64'd0);
      chk("abort_quiet_d", 64'(done), 64'd0);
    end

    // async reset while in SEND
    @(negedge clk);
    first_reg = 5'd10;
    last_reg  = 5'd20;
    out_ready = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("send_valid", 64'(out_valid), 64'd1);
    chk("send_busy", 64'(busy), 64'd1);
    chk("send_A", 64'(A), 64'd10);
    #2 Reset = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_A", 64'(A), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_done", 64'(done), 64'd0);
    end
    kick(7, 7);
    drain(0, -1, 0);
    chk("single_count", 64'(hs_cyc.size()), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
